sc_ulpi_rif: RTL and testbench

//  ULPI register-interface bus sequencer: the responder for REG_REQ transactions from the

---
 rtl/sc_ulpi_rif_pkg.sv | 28 ++
 rtl/sc_ulpi_rif_if.sv | 30 +++
 rtl/sc_ulpi_rif.sv | 147 ++++++++++++++
 tb/tb_sc_ulpi_rif.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sc_ulpi_rif_pkg.sv
// Shared types for the ULPI register-interface sequencer: command codes, PHY register map,
// sequencer states and the saturating counter helper.
package sc_ulpi_pkg;

    typedef enum logic [1:0] {
        ccdRegWrite = 2'b10,
        ccdRegRead  = 2'b11
    } ccd_e;

    typedef enum logic [5:0] {
        regVendorIdLo = 6'h00,
        regFuncCtrl   = 6'h04,
        regIfCtrl     = 6'h07,
        regOtgCtrl    = 6'h0A,
        regExtAddr    = 6'h2F
    } ulpiRegMap_e;

    localparam logic [5:0] EXT_ADDR_CODE = 6'(regExtAddr);

    typedef enum logic [3:0] {
        IDLE, CMD, EXT, WDATA, STOP, RTURN, RDATA, RDONE, ACK, ABWAIT
    } rifState_t;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/sc_ulpi_rif_if.sv
// Register-request handshake plus ULPI pin bundle; slave is the sequencer, master is the
// register controller / PHY side.
interface sc_ulpi_rif_if;
    logic       REG_REQ;
    logic       REG_ACK;
    logic [1:0] REG_CCD;
    logic [5:0] REG_CPD;
    logic [7:0] REG_EXT_ADDR;
    logic [7:0] REG_TX_DATA;
    logic [7:0] ULPI_DATA;
    logic       ULPI_DIR;
    logic       ULPI_NXT;
    logic       ULPI_STP;
    logic [7:0] ULPI_DI;
    logic [7:0] ULPI_DO;
    logic       ULPI_DOE;
    logic [7:0] ABORT_CNT;

    modport slave (
        input  REG_REQ, REG_CCD, REG_CPD, REG_EXT_ADDR, REG_TX_DATA,
               ULPI_DIR, ULPI_NXT, ULPI_DI,
        output REG_ACK, ULPI_DATA, ULPI_STP, ULPI_DO, ULPI_DOE, ABORT_CNT
    );

    modport master (
        output REG_REQ, REG_CCD, REG_CPD, REG_EXT_ADDR, REG_TX_DATA,
               ULPI_DIR, ULPI_NXT, ULPI_DI,
        input  REG_ACK, ULPI_DATA, ULPI_STP, ULPI_DO, ULPI_DOE, ABORT_CNT
    );
endinterface

// File: rtl/sc_ulpi_rif.sv
// ULPI register write/read sequencer with abort/timeout retry; write acks 4 cycles after accept,
// read 5. NXT throttles each byte; DIR high pre-empts the bus and forces a retry.
module sc_ulpi_rif
    import sc_ulpi_pkg::*;
#(
    parameter int NXT_TO_CYC = 255
) (
    input  logic         ULPICLK,
    input  logic         ULPIRST,
    sc_ulpi_rif_if.slave bus
);

    rifState_t  state;
    logic [1:0] ccd_q;
    logic [5:0] cpd_q;
    logic [7:0] ext_q;
    logic [7:0] tx_q;
    logic [7:0] to_cnt;
    logic [7:0] do_q;
    logic [7:0] data_q;
    logic [7:0] abort_q;
    logic       ack_q;
    logic       stp_q;
    logic       ab_gap;
    logic       is_wr;
    logic       ext_sel;
    logic       to_hit;

    assign is_wr   = (ccd_q == ccdRegWrite);
    assign ext_sel = (cpd_q == EXT_ADDR_CODE);
    assign to_hit  = !bus.ULPI_NXT && (to_cnt == 8'(NXT_TO_CYC - 1));

    assign bus.ULPI_DOE  = !bus.ULPI_DIR;
    assign bus.ULPI_DO   = do_q;
    assign bus.ULPI_STP  = stp_q;
    assign bus.REG_ACK   = ack_q;
    assign bus.ULPI_DATA = data_q;
    assign bus.ABORT_CNT = abort_q;

    // Outputs are registered alongside the state: each transition also loads the byte and
    // strobes that belong to the state being entered.
    always_ff @(posedge ULPICLK) begin
        if (ULPIRST) begin
            state   <= IDLE;
            ccd_q   <= 2'b00;
            cpd_q   <= 6'h00;
            ext_q   <= 8'h00;
            tx_q    <= 8'h00;
            to_cnt  <= 8'h00;
            do_q    <= 8'h00;
            data_q  <= 8'h00;
            abort_q <= 8'h00;
            ack_q   <= 1'b0;
            stp_q   <= 1'b0;
            ab_gap  <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            stp_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.REG_REQ && !ack_q && !bus.ULPI_DIR) begin
                        ccd_q  <= bus.REG_CCD;
                        cpd_q  <= bus.REG_CPD;
                        ext_q  <= bus.REG_EXT_ADDR;
                        tx_q   <= bus.REG_TX_DATA;
                        do_q   <= {bus.REG_CCD, bus.REG_CPD};
                        to_cnt <= 8'h00;
                        state  <= CMD;
                    end
                end
                CMD, EXT, WDATA: begin
                    // DIR wins over a simultaneous NXT: the PHY has already taken the bus.
                    if (bus.ULPI_DIR) begin
                        state   <= ABWAIT;
                        do_q    <= 8'h00;
                        ab_gap  <= 1'b0;
                        abort_q <= sat_inc(abort_q);
                    end else if (bus.ULPI_NXT) begin
                        to_cnt <= 8'h00;
                        if (state == CMD && ext_sel) begin
                            state <= EXT;
                            do_q  <= ext_q;
                        end else if (state != WDATA && is_wr) begin
                            state <= WDATA;
                            do_q  <= tx_q;
                        end else if (state != WDATA) begin
                            state <= RTURN;
                            do_q  <= 8'h00;
                        end else begin
                            state <= STOP;
                            do_q  <= 8'h00;
                            stp_q <= 1'b1;
                        end
                    end else if (to_hit) begin
                        state   <= ABWAIT;
                        do_q    <= 8'h00;
                        stp_q   <= 1'b1;
                        ab_gap  <= 1'b0;
                        to_cnt  <= 8'h00;
                        abort_q <= sat_inc(abort_q);
                    end else begin
                        to_cnt <= to_cnt + 8'd1;
                    end
                end
                STOP: begin
                    state <= ACK;
                    ack_q <= 1'b1;
                end
                RTURN: begin
                    if (bus.ULPI_DIR) begin
                        state <= RDATA;
                    end else begin
                        state   <= ABWAIT;
                        ab_gap  <= 1'b0;
                        abort_q <= sat_inc(abort_q);
                    end
                end
                RDATA: begin
                    data_q <= bus.ULPI_DI;
                    state  <= RDONE;
                end
                RDONE: begin
                    if (!bus.ULPI_DIR) begin
                        state <= ACK;
                        ack_q <= 1'b1;
                    end
                end
                ACK: state <= IDLE;
                ABWAIT: begin
                    // Needs DIR low for one cycle plus one further idle cycle before retrying.
                    if (bus.ULPI_DIR) begin
                        ab_gap <= 1'b0;
                    end else if (!ab_gap) begin
                        ab_gap <= 1'b1;
                    end else begin
                        ab_gap <= 1'b0;
                        to_cnt <= 8'h00;
                        do_q   <= {ccd_q, cpd_q};
                        state  <= CMD;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sc_ulpi_rif.sv
// Bench for sc_ulpi_rif: plays register controller and PHY, predicting bus bytes, strobes,
// read data and abort count from transfer-level rules.
module tb_sc_ulpi_rif;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sc_ulpi_rif_if bus();

    sc_ulpi_rif #(.NXT_TO_CYC(255)) dut (
        .ULPICLK (clk),
        .ULPIRST (rst),
        .bus     (bus)
    );

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_abort = 8'h00;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Land just after the active edge: outputs for this cycle are settled, inputs may change.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_req(input logic wr, input logic [5:0] cpd, input logic [7:0] ext,
                             input logic [7:0] tx);
        step();
        chk("idle_do", bus.ULPI_DO, 8'h00);
        chk("idle_ack", bus.REG_ACK, 1'b0);
        bus.REG_REQ      = 1'b1;
        bus.REG_CCD      = wr ? 2'b10 : 2'b11;
        bus.REG_CPD      = cpd;
        bus.REG_EXT_ADDR = ext;
        bus.REG_TX_DATA  = tx;
        bus.ULPI_DIR     = 1'b0;
        bus.ULPI_NXT     = 1'b0;
    endtask

    // Each byte is held on DO until the PHY gives NXT after w stalled cycles.
    task automatic bytes_phase(input logic [7:0] b [3], input int n, input int first,
                               input int wmin, input int wmax);
        for (int i = first; i < n; i++) begin
            int w;
            w = $urandom_range(wmax, wmin);
            for (int k = 0; k <= w; k++) begin
                step();
                chk("byte_do", bus.ULPI_DO, b[i]);
                chk("byte_stp", bus.ULPI_STP, 1'b0);
                chk("byte_ack", bus.REG_ACK, 1'b0);
                bus.ULPI_NXT = (k == w);
            end
        end
    endtask

    task automatic finish_write();
        step();
        chk("stop_do", bus.ULPI_DO, 8'h00);
        chk("stop_stp", bus.ULPI_STP, 1'b1);
        chk("stop_ack", bus.REG_ACK, 1'b0);
        bus.ULPI_NXT = 1'b0;
        step();
        chk("wr_ack", bus.REG_ACK, 1'b1);
        chk("wr_ack_stp", bus.ULPI_STP, 1'b0);
        step();
        chk("wr_ack_pulse", bus.REG_ACK, 1'b0);
        bus.REG_REQ = 1'b0;
    endtask

    task automatic finish_read(input logic [7:0] di, input int hold);
        step();
        chk("rturn_do", bus.ULPI_DO, 8'h00);
        chk("rturn_stp", bus.ULPI_STP, 1'b0);
        bus.ULPI_NXT = 1'b0;
        bus.ULPI_DIR = 1'b1;
        #1;
        chk("doe_dir_high", bus.ULPI_DOE, 1'b0);
        step();
        chk("rdata_ack", bus.REG_ACK, 1'b0);
        bus.ULPI_DI = di;
        for (int h = 0; h < hold; h++) begin
            step();
            chk("rdone_hold_ack", bus.REG_ACK, 1'b0);
            bus.ULPI_DI = ~di;
        end
        step();
        chk("rdone_ack", bus.REG_ACK, 1'b0);
        bus.ULPI_DIR = 1'b0;
        bus.ULPI_DI  = ~di;
        #1;
        chk("doe_dir_low", bus.ULPI_DOE, 1'b1);
        step();
        chk("rd_ack", bus.REG_ACK, 1'b1);
        chk("rd_data", bus.ULPI_DATA, di);
        step();
        chk("rd_ack_pulse", bus.REG_ACK, 1'b0);
        bus.REG_REQ = 1'b0;
    endtask

    task automatic build(input logic wr, input logic [5:0] cpd, input logic [7:0] ext,
                         input logic [7:0] tx, output logic [7:0] b [3], output int n);
        b[0] = {(wr ? 2'b10 : 2'b11), cpd};
        b[1] = 8'h00;
        b[2] = 8'h00;
        n = 1;
        if (cpd == 6'h2F) begin b[n] = ext; n++; end
        if (wr)           begin b[n] = tx;  n++; end
    endtask

    task automatic xfer(input logic wr, input logic [5:0] cpd, input logic [7:0] ext,
                        input logic [7:0] tx, input logic [7:0] di,
                        input int wmin, input int wmax, input int hold);
        logic [7:0] b [3];
        int n;
        build(wr, cpd, ext, tx, b, n);
        start_req(wr, cpd, ext, tx);
        bytes_phase(b, n, 0, wmin, wmax);
        if (wr) finish_write();
        else    finish_read(di, hold);
    endtask

    task automatic wait_retry(input logic [7:0] b0);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            step();
            chk("retry_no_ack", bus.REG_ACK, 1'b0);
            bus.ULPI_DIR = 1'b0;
            bus.ULPI_NXT = 1'b0;
            if (bus.ULPI_DO == b0) begin
                found = 1'b1;
                bus.ULPI_NXT = 1'b1;
            end
        end
        chk("retry_cmd_seen", found, 1'b1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] b [3];
        int n;

        rst = 1'b1;
        bus.REG_REQ = 1'b0; bus.REG_CCD = 2'b00; bus.REG_CPD = 6'h00;
        bus.REG_EXT_ADDR = 8'h00; bus.REG_TX_DATA = 8'h00;
        bus.ULPI_DIR = 1'b0; bus.ULPI_NXT = 1'b0; bus.ULPI_DI = 8'h00;
        step(); step();
        chk("rst_ack", bus.REG_ACK, 1'b0);
        chk("rst_stp", bus.ULPI_STP, 1'b0);
        chk("rst_do", bus.ULPI_DO, 8'h00);
        chk("rst_data", bus.ULPI_DATA, 8'h00);
        chk("rst_abort", bus.ABORT_CNT, 8'h00);
        chk("rst_doe", bus.ULPI_DOE, 1'b1);
        rst = 1'b0;

        // Plain write and read of register 0A
        xfer(1'b1, 6'h0A, 8'h00, 8'h06, 8'h00, 0, 0, 0);
        xfer(1'b0, 6'h0A, 8'h00, 8'h00, 8'h66, 0, 0, 0);
        // Extended-address write, every byte stalled three cycles
        xfer(1'b1, 6'h2F, 8'h85, 8'h5A, 8'h00, 3, 3, 0);

        // DIR rises in the data cycle while NXT is also high
        build(1'b1, 6'h0A, 8'h00, 8'h33, b, n);
        start_req(1'b1, 6'h0A, 8'h00, 8'h33);
        step();
        chk("ab_cmd_do", bus.ULPI_DO, 8'h8A);
        bus.ULPI_NXT = 1'b1;
        step();
        chk("ab_wdata_do", bus.ULPI_DO, 8'h33);
        bus.ULPI_DIR = 1'b1;
        #1;
        chk("ab_doe", bus.ULPI_DOE, 1'b0);
        step();
        exp_abort = exp_abort + 8'd1;
        chk("ab_cnt", bus.ABORT_CNT, exp_abort);
        chk("ab_no_ack", bus.REG_ACK, 1'b0);
        bus.ULPI_NXT = 1'b0;
        step();
        chk("ab_hold_no_ack", bus.REG_ACK, 1'b0);
        wait_retry(8'h8A);
        bytes_phase(b, n, 1, 0, 1);
        finish_write();

        // Extended read with the PHY never answering the turnaround
        build(1'b0, 6'h2F, 8'hC3, 8'h00, b, n);
        start_req(1'b0, 6'h2F, 8'hC3, 8'h00);
        bytes_phase(b, n, 0, 0, 1);
        step();
        chk("rt_ab_do", bus.ULPI_DO, 8'h00);
        bus.ULPI_NXT = 1'b0;
        step();
        exp_abort = exp_abort + 8'd1;
        chk("rt_ab_cnt", bus.ABORT_CNT, exp_abort);
        wait_retry(8'hEF);
        bytes_phase(b, n, 1, 0, 0);
        finish_read(8'h3C, 1);

        // NXT never arrives: 255 command cycles, then a forced stop and a retry
        build(1'b1, 6'h04, 8'h00, 8'h11, b, n);
        start_req(1'b1, 6'h04, 8'h00, 8'h11);
        for (int i = 0; i < 255; i++) begin
            step();
            chk("to_cmd_do", bus.ULPI_DO, 8'h84);
            chk("to_cmd_stp", bus.ULPI_STP, 1'b0);
        end
        step();
        exp_abort = exp_abort + 8'd1;
        chk("to_stp", bus.ULPI_STP, 1'b1);
        chk("to_do", bus.ULPI_DO, 8'h00);
        chk("to_cnt", bus.ABORT_CNT, exp_abort);
        wait_retry(8'h84);
        bytes_phase(b, n, 1, 0, 2);
        finish_write();

        // Back-to-back write then read, request low for a single cycle in between
        xfer(1'b1, 6'h16, 8'h00, 8'hA5, 8'h00, 0, 1, 0);
        xfer(1'b0, 6'h16, 8'h00, 8'h00, 8'h5A, 0, 1, 0);

        for (int t = 0; t < 24; t++) begin
            logic       wr;
            logic [5:0] cpd;
            wr  = 1'($urandom_range(1, 0));
            cpd = ($urandom_range(3, 0) == 0) ? 6'h2F : 6'($urandom);
            xfer(wr, cpd, 8'($urandom), 8'($urandom), 8'($urandom), 0, 3,
                 $urandom_range(2, 0));
        end
        chk("abort_total", bus.ABORT_CNT, exp_abort);

        // Reset while the command byte is on the bus
        start_req(1'b1, 6'h0A, 8'h00, 8'h55);
        step();
        chk("rs_cmd_do", bus.ULPI_DO, 8'h8A);
        rst = 1'b1;
        step();
        chk("rs_do", bus.ULPI_DO, 8'h00);
        chk("rs_stp", bus.ULPI_STP, 1'b0);
        chk("rs_ack", bus.REG_ACK, 1'b0);
        chk("rs_abort", bus.ABORT_CNT, 8'h00);
        rst = 1'b0;
        bus.REG_REQ = 1'b0;
        exp_abort = 8'h00;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("rs_idle_ack", bus.REG_ACK, 1'b0);
            chk("rs_idle_do", bus.ULPI_DO, 8'h00);
        end
        xfer(1'b0, 6'h07, 8'h00, 8'h00, 8'h9E, 1, 2, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
